// File: rtl/kirsch_pkg.sv
// Shared definitions for the Kirsch/AMSG window generator and kernel blocks.
// Holds the default pixel width, the pixel type and the 3x3 window
// position indices (p1..p9, raster order, centre = 5).
package kirsch_pkg;

  localparam int DEF_PIX_W = 8;

  // 3x3 window positions: top row L..R, centre row, bottom row
  localparam int P_TL = 1;
  localparam int P_TC = 2;
  localparam int P_TR = 3;
  localparam int P_ML = 4;
  localparam int P_C  = 5;
  localparam int P_MR = 6;
  localparam int P_BL = 7;
  localparam int P_BC = 8;
  localparam int P_BR = 9;

  typedef logic [DEF_PIX_W-1:0] pix_t;

endpackage

// File: rtl/kirsch_line_buffer.sv
// One image line of pixel storage: asynchronous read, synchronous write.
// Ports: clk, wr_en, addr (shared read/write address), wr_data, rd_data.
// rd_data shows the old contents of addr during a write (read-before-write).
module kirsch_line_buffer
  import kirsch_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int PIX_W = DEF_PIX_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wr_data,
  output logic [PIX_W-1:0] rd_data
);

  // Not reset: stale contents are never used by an emitted window.
  logic [PIX_W-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/kirsch_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, interior-centred windows out.
// Ports: clk/rst_n; in_pix/in_sof/in_valid/in_ready pixel stream;
// p1..p9/out_last/out_valid/out_ready window stream. Latency 1 cycle accept->window.
module kirsch_window_gen
  import kirsch_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_sof,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p4,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic [PIX_W-1:0] p9,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]    col_q, col_eff;
  logic [RW-1:0]    row_q, row_eff;
  logic             accept, emit, at_eol, at_eof;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  // Two previously accepted columns: *2_q is column c-2, *1_q is column c-1.
  logic [PIX_W-1:0] top2_q, top1_q, mid2_q, mid1_q, bot2_q, bot1_q;

  logic [PIX_W-1:0] win_nxt [1:9];
  logic [PIX_W-1:0] win_q   [1:9];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // in_sof forces the pixel to (0,0) whatever the counters hold.
  assign col_eff = in_sof ? '0 : col_q;
  assign row_eff = in_sof ? '0 : row_q;
  assign at_eol  = (col_eff == C_LAST);
  assign at_eof  = at_eol && (row_eff == R_LAST);
  // c>=2 keeps all three columns on the current line.
  assign emit    = accept && (row_eff >= RW'(2)) && (col_eff >= CW'(2));

  kirsch_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W), .AW(CW)) u_lb0 (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (col_eff),
    .wr_data (in_pix),
    .rd_data (lb0_rd)
  );

  kirsch_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W), .AW(CW)) u_lb1 (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (col_eff),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  // Window as seen after shifting in the current column {lb1, lb0, in_pix}.
  always_comb begin
    win_nxt[P_TL] = top2_q;
    win_nxt[P_TC] = top1_q;
    win_nxt[P_TR] = lb1_rd;
    win_nxt[P_ML] = mid2_q;
    win_nxt[P_C]  = mid1_q;
    win_nxt[P_MR] = lb0_rd;
    win_nxt[P_BL] = bot2_q;
    win_nxt[P_BC] = bot1_q;
    win_nxt[P_BR] = in_pix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      top2_q <= '0;
      top1_q <= '0;
      mid2_q <= '0;
      mid1_q <= '0;
      bot2_q <= '0;
      bot1_q <= '0;
    end else if (accept) begin
      col_q <= at_eol ? '0 : col_eff + CW'(1);
      if (at_eol) row_q <= (row_eff == R_LAST) ? '0 : row_eff + RW'(1);
      else        row_q <= row_eff;
      top2_q <= top1_q;
      top1_q <= lb1_rd;
      mid2_q <= mid1_q;
      mid1_q <= lb0_rd;
      bot2_q <= bot1_q;
      bot1_q <= in_pix;
    end
  end

  // Single output stage; emit can only happen when the stage is free or
  // being consumed this cycle, since accept already requires in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= 9; i++) win_q[i] <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (emit) begin
      win_q     <= win_nxt;
      out_last  <= at_eof;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign p1 = win_q[P_TL];
  assign p2 = win_q[P_TC];
  assign p3 = win_q[P_TR];
  assign p4 = win_q[P_ML];
  assign p5 = win_q[P_C];
  assign p6 = win_q[P_MR];
  assign p7 = win_q[P_BL];
  assign p8 = win_q[P_BC];
  assign p9 = win_q[P_BR];

endmodule
